rv32i_inst_encoder: RTL and testbench
=====================================

// Module: rv32i_inst_encoder
// PURPOSE
// - Inverse of the ID-stage decoder: takes instruction fields (class, Fn3, alt bit, rd/rs1/rs2, imm) over a valid/ready handshake.
// - Builds the 32-bit RV32I word and range-checks the immediate.
// - Writes each legal word into instruction BRAM through a byte-enable write port, at a self-incrementing byte address.
// - Used for on-chip program loading and self-test generation.
// PARAMETERS
// ADDR_W    12   instruction memory byte-address width; address wraps modulo 2^ADDR_W
// CNT_W     16   width of the written-word counter (saturating)
// PORTS
// CPU_CLK      in   1       clock, all logic on rising edge
// CPU_RST      in   1       asynchronous reset, active-high
// LoadBase     in   1       load BaseAddr into the address pointer (honoured only in IDLE)
// BaseAddr     in   ADDR_W  new pointer value; bits[1:0] are forced to 0
// InValid      in   1       field bundle valid
// InReady      out  1       encoder can accept a bundle
// InClass      in   4       0 R, 1 I-ALU, 2 I-shift, 3 LOAD, 4 STORE, 5 BRANCH, 6 LUI, 7 AUIPC, 8 JAL, 9 JALR
// InFn3        in   3       funct3
// InAlt        in   1       Fn7=0100000 (sub/sra/srai); otherwise 0000000
// InRd/InRs1/InRs2  in  5 each  register indices
// InImm        in   32      immediate as a signed byte value; U-type takes the full upper value
// ImemWrAddr   out  ADDR_W  write byte address
// ImemWrData   out  32      encoded instruction
// ImemWrEn     out  4       byte enables: 4'b1111 during a write, else 4'b0000
// EncErr       out  1       one-cycle pulse: bundle rejected
// WordCnt      out  CNT_W   number of words written since reset
// BEHAVIOUR
// - Reset values: FSM=IDLE; InReady=1; ImemWrAddr=0; ImemWrData=0; ImemWrEn=0; EncErr=0; WordCnt=0.
// - FSM states: IDLE -> ENC -> WRITE -> IDLE, or IDLE -> ENC -> IDLE on error.
// - IDLE: InReady=1. InValid&InReady captures the bundle into registers and moves to ENC.
//   - LoadBase in the same cycle also updates the pointer before capture, so the captured word goes to BaseAddr.
// - ENC: InReady=0. The encoded word is registered into ImemWrData and checks are performed.
//   - Illegal: EncErr pulses this cycle, return to IDLE; no write, pointer and WordCnt unchanged.
//   - Legal: go to WRITE.
// - WRITE: ImemWrEn=4'b1111 for exactly one cycle at ImemWrAddr.
//   - Next cycle: pointer += 4 (wraps to 0 after 2^ADDR_W-4), WordCnt += 1 (saturates at all-ones), return to IDLE.
// - Latency: handshake at cycle N -> ImemWrEn high at N+2. Throughput: one word per 3 cycles.
// - Opcodes: R 0110011, I-ALU/I-shift 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, LUI 0110111,
//   AUIPC 0010111, JAL 1101111, JALR 1100111 (JALR Fn3 forced to 000).
// - Fn7 = InAlt ? 0100000 : 0000000 for R and I-shift; ignored for other classes.
// - Immediate legality:
//   - I/S/JALR: InImm[31:11] all equal (12-bit signed).
//   - I-shift: InImm[31:5]==0; imm field = {Fn7, InImm[4:0]}.
//   - B: InImm[0]==0 and InImm[31:12] all equal.
//   - J: InImm[0]==0 and InImm[31:20] all equal.
//   - U: InImm[11:0]==0.
// - Fn3 legality:
//   - R: InAlt only with Fn3 000 or 101.
//   - I-ALU: Fn3 not 001/101 (those belong to I-shift).
//   - I-shift: Fn3 001 or 101; InAlt only with 101.
//   - LOAD: 000,001,010,100,101.
//   - STORE: 000..010.
//   - BRANCH: not 010/011.
// - Any InClass > 9 is illegal.
// - LoadBase outside IDLE is ignored. InValid outside IDLE is not accepted; the sender holds it.
// - CPU_RST asserted mid-operation aborts immediately: ImemWrEn drops asynchronously, no partial write, FSM returns to IDLE.
// TESTING
// - addi x1,x0,5 (class1,Fn3 000,imm 5) -> ImemWrData=0x00500093, ImemWrEn=1111 at addr 0, 2 cycles after handshake.
// - sub x3,x1,x2 (class0,Alt=1) at addr 4 -> 0x402081B3. sw x2,8(x1) at addr 8 -> 0x0020A423.
// - beq x0,x0,-4 -> 0xFE000EE3. jal x1,8 -> 0x008000EF. lui x5,0x12345000 -> 0x123452B7.
// - addi imm=2048, beq imm=3, slli imm=32, class 12 -> each EncErr pulse, no ImemWrEn, pointer and WordCnt unchanged.
// - LoadBase=1, BaseAddr=0xFFE, then 2 legal words -> writes at 0xFFC and 0x000 (wrap); WordCnt +2.
// - CPU_RST pulsed during WRITE -> ImemWrEn=0 immediately; after release all outputs at reset values and InReady=1.

Source files
------------

// File: rtl/rv32i_inst_encoder_if.sv
// Field-bundle handshake and instruction-memory write port of the RV32I encoder.
// The master side supplies instruction fields; the slave side is the encoder.
interface rv32i_inst_encoder_if #(
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 16
);
  logic              LoadBase;
  logic [ADDR_W-1:0] BaseAddr;
  logic              InValid;
  logic              InReady;
  logic [3:0]        InClass;
  logic [2:0]        InFn3;
  logic              InAlt;
  logic [4:0]        InRd;
  logic [4:0]        InRs1;
  logic [4:0]        InRs2;
  logic [31:0]       InImm;
  logic [ADDR_W-1:0] ImemWrAddr;
  logic [31:0]       ImemWrData;
  logic [3:0]        ImemWrEn;
  logic              EncErr;
  logic [CNT_W-1:0]  WordCnt;

  modport master (
    output LoadBase, BaseAddr, InValid, InClass, InFn3, InAlt, InRd, InRs1, InRs2, InImm,
    input  InReady, ImemWrAddr, ImemWrData, ImemWrEn, EncErr, WordCnt
  );

  modport slave (
    input  LoadBase, BaseAddr, InValid, InClass, InFn3, InAlt, InRd, InRs1, InRs2, InImm,
    output InReady, ImemWrAddr, ImemWrData, ImemWrEn, EncErr, WordCnt
  );
endinterface

// File: rtl/rv32i_inst_encoder.sv
// Encodes RV32I field bundles into 32-bit words, range-checks them, and writes
// legal words into instruction memory at a self-incrementing byte address.
module rv32i_inst_encoder #(
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 16
) (
  input  logic                 CPU_CLK,
  input  logic                 CPU_RST,
  rv32i_inst_encoder_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ENC   = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic [1:0]        r_state;
  logic [3:0]        r_cls;
  logic [2:0]        r_fn3;
  logic              r_alt;
  logic [4:0]        r_rd;
  logic [4:0]        r_rs1;
  logic [4:0]        r_rs2;
  logic [31:0]       r_imm;
  logic [ADDR_W-1:0] r_ptr;
  logic [31:0]       r_data;
  logic [CNT_W-1:0]  r_cnt;

  logic [6:0]  w_fn7;
  logic [31:0] w_word;
  logic        w_imm_ok;
  logic        w_fn3_ok;
  logic        w_legal;
  logic        w_s11;
  logic        w_s12;
  logic        w_s20;
  logic        w_unused_base;

  // Sign-run checks: bits from the top down to the field's sign bit must all match.
  assign w_s11 = (&r_imm[31:11]) | ~(|r_imm[31:11]);
  assign w_s12 = (&r_imm[31:12]) | ~(|r_imm[31:12]);
  assign w_s20 = (&r_imm[31:20]) | ~(|r_imm[31:20]);
  assign w_fn7 = r_alt ? 7'b0100000 : 7'b0000000;

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    w_word   = '0;
    w_imm_ok = 1'b0;
    w_fn3_ok = 1'b0;
    case (r_cls)
      4'd0: begin
        w_word   = {w_fn7, r_rs2, r_rs1, r_fn3, r_rd, OP_R};
        w_imm_ok = 1'b1;
        w_fn3_ok = !r_alt || (r_fn3 == 3'b000) || (r_fn3 == 3'b101);
      end
      4'd1: begin
        w_word   = {r_imm[11:0], r_rs1, r_fn3, r_rd, OP_IMM};
        w_imm_ok = w_s11;
        w_fn3_ok = (r_fn3 != 3'b001) && (r_fn3 != 3'b101);
      end
      4'd2: begin
        w_word   = {w_fn7, r_imm[4:0], r_rs1, r_fn3, r_rd, OP_IMM};
        w_imm_ok = ~(|r_imm[31:5]);
        w_fn3_ok = (r_fn3 == 3'b101) || ((r_fn3 == 3'b001) && !r_alt);
      end
      4'd3: begin
        w_word   = {r_imm[11:0], r_rs1, r_fn3, r_rd, OP_LOAD};
        w_imm_ok = w_s11;
        w_fn3_ok = (r_fn3 != 3'b011) && (r_fn3 != 3'b110) && (r_fn3 != 3'b111);
      end
      4'd4: begin
        w_word   = {r_imm[11:5], r_rs2, r_rs1, r_fn3, r_imm[4:0], OP_STORE};
        w_imm_ok = w_s11;
        w_fn3_ok = (r_fn3 <= 3'b010);
      end
      4'd5: begin
        w_word   = {r_imm[12], r_imm[10:5], r_rs2, r_rs1, r_fn3, r_imm[4:1], r_imm[11], OP_BRANCH};
        w_imm_ok = !r_imm[0] && w_s12;
        w_fn3_ok = (r_fn3 != 3'b010) && (r_fn3 != 3'b011);
      end
      4'd6: begin
        w_word   = {r_imm[31:12], r_rd, OP_LUI};
        w_imm_ok = ~(|r_imm[11:0]);
        w_fn3_ok = 1'b1;
      end
      4'd7: begin
        w_word   = {r_imm[31:12], r_rd, OP_AUIPC};
        w_imm_ok = ~(|r_imm[11:0]);
        w_fn3_ok = 1'b1;
      end
      4'd8: begin
        w_word   = {r_imm[20], r_imm[10:1], r_imm[11], r_imm[19:12], r_rd, OP_JAL};
        w_imm_ok = !r_imm[0] && w_s20;
        w_fn3_ok = 1'b1;
      end
      4'd9: begin
        w_word   = {r_imm[11:0], r_rs1, 3'b000, r_rd, OP_JALR};
        w_imm_ok = w_s11;
        w_fn3_ok = 1'b1;
      end
      default: begin
        w_word   = '0;
        w_imm_ok = 1'b0;
        w_fn3_ok = 1'b0;
      end
    endcase
  end

  assign w_legal = w_imm_ok && w_fn3_ok;

  // NOTE: sequential state uses non-blocking assignments only, with an asynchronous reset.
  always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
    if (CPU_RST) begin
      r_state <= S_IDLE;
      r_cls   <= '0;
      r_fn3   <= '0;
      r_alt   <= 1'b0;
      r_rd    <= '0;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_imm   <= '0;
      r_ptr   <= '0;
      r_data  <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.LoadBase) r_ptr <= {bus.BaseAddr[ADDR_W-1:2], 2'b00};
          if (bus.InValid) begin
            r_cls   <= bus.InClass;
            r_fn3   <= bus.InFn3;
            r_alt   <= bus.InAlt;
            r_rd    <= bus.InRd;
            r_rs1   <= bus.InRs1;
            r_rs2   <= bus.InRs2;
            r_imm   <= bus.InImm;
            r_state <= S_ENC;
          end
        end
        S_ENC: begin
          r_data  <= w_word;
          r_state <= w_legal ? S_WRITE : S_IDLE;
        end
        S_WRITE: begin
          r_ptr   <= r_ptr + ADDR_W'(4);
          r_cnt   <= (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode straight from the state so reset drops the write enable at once.
  assign bus.InReady    = (r_state == S_IDLE);
  assign bus.ImemWrEn   = (r_state == S_WRITE) ? 4'b1111 : 4'b0000;
  assign bus.EncErr     = (r_state == S_ENC) && !w_legal;
  assign bus.ImemWrAddr = r_ptr;
  assign bus.ImemWrData = r_data;
  assign bus.WordCnt    = r_cnt;

  assign w_unused_base = ^bus.BaseAddr[1:0];

endmodule

// File: tb/tb_rv32i_inst_encoder.sv
// Self-checking bench for rv32i_inst_encoder: directed vector table, corner
// sequences (wrap, late LoadBase, reset during write) and random bundles.
module tb_rv32i_inst_encoder;

  localparam int ADDR_W = 12;
  localparam int CNT_W  = 16;

  typedef struct {
    logic [3:0]  cls;
    logic [2:0]  fn3;
    logic        alt;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    bit          exp_err;
    logic [31:0] exp_word;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rv32i_inst_encoder_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

  rv32i_inst_encoder #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .CPU_CLK(clk),
    .CPU_RST(rst),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [ADDR_W-1:0] m_ptr = '0;
  logic [CNT_W-1:0]  m_cnt = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference encoder built from the ISA rules with integer ranges and shifts.
  function automatic void ref_encode(input logic [31:0] cls, fn3, alt, rd, rs1, rs2, imm,
                                     output bit legal, output logic [31:0] word);
    int s;
    logic [31:0] f7;
    bit in12;
    s     = $signed(imm);
    f7    = (alt != 0) ? 32'h20 : 32'h0;
    in12  = (s >= -2048) && (s <= 2047);
    legal = 1'b0;
    word  = 32'h0;
    case (cls)
      0: begin
        legal = (alt == 0) || (fn3 == 0) || (fn3 == 5);
        word  = (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (fn3 << 12) | (rd << 7) | 32'h33;
      end
      1: begin
        legal = in12 && (fn3 != 1) && (fn3 != 5);
        word  = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (fn3 << 12) | (rd << 7) | 32'h13;
      end
      2: begin
        legal = (imm < 32) && ((fn3 == 5) || ((fn3 == 1) && (alt == 0)));
        word  = (f7 << 25) | ((imm & 32'h1F) << 20) | (rs1 << 15) | (fn3 << 12) | (rd << 7) | 32'h13;
      end
      3: begin
        legal = in12 && (fn3 inside {0, 1, 2, 4, 5});
        word  = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (fn3 << 12) | (rd << 7) | 32'h03;
      end
      4: begin
        legal = in12 && (fn3 <= 2);
        word  = (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (fn3 << 12)
              | ((imm & 32'h1F) << 7) | 32'h23;
      end
      5: begin
        legal = (imm % 2 == 0) && (s >= -4096) && (s <= 4095) && (fn3 != 2) && (fn3 != 3);
        word  = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20) | (rs1 << 15)
              | (fn3 << 12) | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 1) << 7) | 32'h63;
      end
      6, 7: begin
        legal = (imm % 4096 == 0);
        word  = (imm & 32'hFFFF_F000) | (rd << 7) | ((cls == 6) ? 32'h37 : 32'h17);
      end
      8: begin
        legal = (imm % 2 == 0) && (s >= -(1 << 20)) && (s <= (1 << 20) - 1);
        word  = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 11) & 1) << 20)
              | (((imm >> 12) & 32'hFF) << 12) | (rd << 7) | 32'h6F;
      end
      9: begin
        legal = in12;
        word  = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (rd << 7) | 32'h67;
      end
      default: begin
        legal = 1'b0;
        word  = 32'h0;
      end
    endcase
  endfunction

  function automatic vec_t mk(input logic [3:0] c, input logic [2:0] f, input logic a,
                              input logic [4:0] rd, rs1, rs2, input logic [31:0] imm,
                              input bit err, input logic [31:0] w);
    vec_t v;
    v.cls = c; v.fn3 = f; v.alt = a; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.imm = imm; v.exp_err = err; v.exp_word = w;
    return v;
  endfunction

  task automatic drive_idle();
    bus.InValid  = 1'b0;
    bus.LoadBase = 1'b0;
    bus.BaseAddr = '0;
    bus.InClass  = '0;
    bus.InFn3    = '0;
    bus.InAlt    = 1'b0;
    bus.InRd     = '0;
    bus.InRs1    = '0;
    bus.InRs2    = '0;
    bus.InImm    = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(bus.InReady), 32'd1);
    check({tag, "_addr"},  32'(bus.ImemWrAddr), 32'd0);
    check({tag, "_data"},  bus.ImemWrData, 32'd0);
    check({tag, "_wren"},  32'(bus.ImemWrEn), 32'd0);
    check({tag, "_err"},   32'(bus.EncErr), 32'd0);
    check({tag, "_cnt"},   32'(bus.WordCnt), 32'd0);
  endtask

  // One bundle: handshake, ENC cycle, optional WRITE cycle, then back in IDLE.
  task automatic issue(input vec_t v, input bit exp_legal, input logic [31:0] exp_word,
                       input bit load, input logic [ADDR_W-1:0] base, input bit late_load);
    int t;
    @(negedge clk);
    bus.InClass = v.cls; bus.InFn3 = v.fn3; bus.InAlt = v.alt;
    bus.InRd = v.rd; bus.InRs1 = v.rs1; bus.InRs2 = v.rs2; bus.InImm = v.imm;
    bus.LoadBase = load; bus.BaseAddr = base; bus.InValid = 1'b1;
    t = 0;
    while (!bus.InReady && t < 8) begin
      @(negedge clk);
      t++;
    end
    if (!bus.InReady) begin
      n_checks++;
      n_errors++;
      $display("FAIL ready_timeout actual=0 expected=1 at t=%0t", $time);
      drive_idle();
      return;
    end
    if (load) m_ptr = {base[ADDR_W-1:2], 2'b00};
    @(posedge clk);
    #1;
    bus.InValid  = 1'b0;
    bus.LoadBase = 1'b0;
    @(negedge clk);
    check("enc_ready", 32'(bus.InReady), 32'd0);
    check("enc_err",   32'(bus.EncErr), exp_legal ? 32'd0 : 32'd1);
    check("enc_wren",  32'(bus.ImemWrEn), 32'd0);
    if (late_load) begin
      bus.LoadBase = 1'b1;
      bus.BaseAddr = 12'h100;
    end
    @(negedge clk);
    if (exp_legal) begin
      check("wr_wren", 32'(bus.ImemWrEn), 32'hF);
      check("wr_data", bus.ImemWrData, exp_word);
      check("wr_addr", 32'(bus.ImemWrAddr), 32'(m_ptr));
      check("wr_err",  32'(bus.EncErr), 32'd0);
      m_ptr = m_ptr + ADDR_W'(4);
      if (m_cnt != '1) m_cnt = m_cnt + CNT_W'(1);
      @(negedge clk);
    end
    check("post_ready", 32'(bus.InReady), 32'd1);
    check("post_wren",  32'(bus.ImemWrEn), 32'd0);
    check("post_addr",  32'(bus.ImemWrAddr), 32'(m_ptr));
    check("post_cnt",   32'(bus.WordCnt), 32'(m_cnt));
    bus.LoadBase = 1'b0;
    bus.BaseAddr = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl [12];
    logic [31:0] edges [13];
    vec_t v;
    bit   m_legal;
    logic [31:0] m_word;

    tbl[0]  = mk(4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5,          1'b0, 32'h0050_0093); // addi x1,x0,5
    tbl[1]  = mk(4'd0, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0,          1'b0, 32'h4020_81B3); // sub x3,x1,x2
    tbl[2]  = mk(4'd4, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8,          1'b0, 32'h0020_A423); // sw x2,8(x1)
    tbl[3]  = mk(4'd5, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC,  1'b0, 32'hFE00_0EE3); // beq x0,x0,-4
    tbl[4]  = mk(4'd8, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd8,          1'b0, 32'h0080_00EF); // jal x1,8
    tbl[5]  = mk(4'd6, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5000,  1'b0, 32'h1234_52B7); // lui x5
    tbl[6]  = mk(4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'hFFFF_F800,  1'b0, 32'h8000_0093); // addi -2048
    tbl[7]  = mk(4'd2, 3'd5, 1'b1, 5'd1, 5'd2, 5'd0, 32'd31,         1'b0, 32'h41F1_5093); // srai x1,x2,31
    tbl[8]  = mk(4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048,       1'b1, 32'h0);         // addi 2048
    tbl[9]  = mk(4'd5, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd3,          1'b1, 32'h0);         // beq odd
    tbl[10] = mk(4'd2, 3'd1, 1'b0, 5'd1, 5'd1, 5'd0, 32'd32,         1'b1, 32'h0);         // slli 32
    tbl[11] = mk(4'd12, 3'd0, 1'b0, 5'd1, 5'd1, 5'd0, 32'd0,         1'b1, 32'h0);         // class 12

    edges = '{32'd2047, 32'd2048, 32'hFFFF_F800, 32'hFFFF_F7FF, 32'd4094, 32'd4096,
              32'hFFFF_F000, 32'd31, 32'd32, 32'h0000_1000, 32'h1234_5000,
              32'h0010_0000, 32'h000F_FFFE};

    drive_idle();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst_in");
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_out");

    for (int i = 0; i < 12; i++)
      issue(tbl[i], !tbl[i].exp_err, tbl[i].exp_word, 1'b0, '0, 1'b0);

    // Pointer wrap: base 0xFFE is aligned down to 0xFFC, next write lands at 0x000.
    issue(tbl[0], 1'b1, 32'h0050_0093, 1'b1, 12'hFFE, 1'b0);
    check("wrap_ptr", 32'(bus.ImemWrAddr), 32'h000);
    issue(tbl[1], 1'b1, 32'h4020_81B3, 1'b0, '0, 1'b0);

    // LoadBase held during ENC/WRITE must not move the pointer.
    issue(tbl[4], 1'b1, 32'h0080_00EF, 1'b0, '0, 1'b1);

    for (int i = 0; i < 300; i++) begin
      v.cls = 4'($urandom_range(0, 11));
      v.fn3 = 3'($urandom_range(0, 7));
      v.alt = ($urandom_range(0, 3) == 0);
      v.rd  = 5'($urandom);
      v.rs1 = 5'($urandom);
      v.rs2 = 5'($urandom);
      case ($urandom_range(0, 3))
        0: v.imm = 32'($signed($urandom_range(0, 80)) - 40);
        1: v.imm = $urandom;
        2: v.imm = edges[$urandom_range(0, 12)];
        default: v.imm = $urandom & 32'hFFFF_F000;
      endcase
      v.exp_err = 1'b0;
      v.exp_word = '0;
      ref_encode(32'(v.cls), 32'(v.fn3), 32'(v.alt), 32'(v.rd), 32'(v.rs1), 32'(v.rs2),
                 v.imm, m_legal, m_word);
      issue(v, m_legal, m_word, ($urandom_range(0, 15) == 0), 12'($urandom), 1'b0);
    end

    // Reset pulsed during WRITE: enable drops immediately, everything back to reset values.
    @(negedge clk);
    bus.InClass = 4'd1; bus.InFn3 = 3'd0; bus.InAlt = 1'b0;
    bus.InRd = 5'd1; bus.InRs1 = 5'd0; bus.InRs2 = 5'd0; bus.InImm = 32'd5;
    bus.InValid = 1'b1;
    @(posedge clk);
    #1;
    bus.InValid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rstw_wren_before", 32'(bus.ImemWrEn), 32'hF);
    #1;
    rst = 1'b1;
    #1;
    check("rstw_wren_now", 32'(bus.ImemWrEn), 32'd0);
    check_reset_outputs("rstw_in");
    @(negedge clk);
    rst = 1'b0;
    m_ptr = '0;
    m_cnt = '0;
    @(negedge clk);
    check_reset_outputs("rstw_out");
    issue(tbl[0], 1'b1, 32'h0050_0093, 1'b0, '0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
